// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O port blocks (input and output side).
// Address codes are addr[7:2] within the 80h..8Ch window.
package io_pkg;

    localparam int NUM_OUT_PORTS = 3;

    localparam logic [5:0] IO_PORT0_SEL  = 6'b100000;
    localparam logic [5:0] IO_PORT1_SEL  = 6'b100001;
    localparam logic [5:0] IO_PORT2_SEL  = 6'b100010;
    localparam logic [5:0] IO_STATUS_SEL = 6'b100011;

    // STATUS word field positions
    localparam int STAT_VALID_LSB = 0;
    localparam int STAT_OVR_LSB   = 8;

    typedef logic [NUM_OUT_PORTS-1:0] port_mask_t;

endpackage

// File: rtl/io_output_mux.sv
// Combinational read-back selector for the output-port block; unmapped codes read 0.
module io_output_mux
    import io_pkg::*;
(
    input  logic [31:0] port0,
    input  logic [31:0] port1,
    input  logic [31:0] port2,
    input  logic [31:0] status,
    input  logic [5:0]  sel_addr,
    output logic [31:0] y
);

    always_comb begin
        y = 32'h0;
        case (sel_addr)
            IO_PORT0_SEL:  y = port0;
            IO_PORT1_SEL:  y = port1;
            IO_PORT2_SEL:  y = port2;
            IO_STATUS_SEL: y = status;
            default:       y = 32'h0;
        endcase
    end

endmodule

// File: rtl/io_output_reg.sv
// CPU-writable output port registers with valid/ack handshake, sticky overrun
// flags (W1C through STATUS) and combinational read-back.
module io_output_reg
    import io_pkg::*;
#(
    parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    input  logic [2:0]  out_ack,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [2:0]  out_valid,
    output logic [31:0] io_read_data
);

    logic [5:0] sel;
    logic [NUM_OUT_PORTS-1:0][31:0] port_q;
    port_mask_t valid_q, ovr_q, wr_port, ovr_set, ovr_clr;
    logic status_wr;
    logic [31:0] status_word;
    logic unused_addr;

    assign sel         = addr[7:2];
    assign unused_addr = ^{addr[31:8], addr[1:0]};
    assign status_wr   = write_io_enable && (sel == IO_STATUS_SEL);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_dec
            assign wr_port[gi] = write_io_enable && (sel == IO_PORT0_SEL + 6'(gi));
        end
    endgenerate

    // An ack arriving with the write means the consumer took the old data: no overrun.
    assign ovr_set = wr_port & valid_q & ~out_ack;
    assign ovr_clr = status_wr ? datain[STAT_OVR_LSB +: NUM_OUT_PORTS] : '0;

    always_ff @(posedge io_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) port_q[i] <= OUT_RESET;
            valid_q <= '0;
            ovr_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++)
                if (wr_port[i]) port_q[i] <= datain;
            valid_q <= wr_port | (valid_q & ~out_ack);
            ovr_q   <= (ovr_q & ~ovr_clr) | ovr_set;
        end
    end

    always_comb begin
        status_word = 32'h0;
        status_word[STAT_VALID_LSB +: NUM_OUT_PORTS] = valid_q;
        status_word[STAT_OVR_LSB   +: NUM_OUT_PORTS] = ovr_q;
    end

    io_output_mux u_mux (
        .port0    (port_q[0]),
        .port1    (port_q[1]),
        .port2    (port_q[2]),
        .status   (status_word),
        .sel_addr (sel),
        .y        (io_read_data)
    );

    assign out_port0 = port_q[0];
    assign out_port1 = port_q[1];
    assign out_port2 = port_q[2];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_io_output_reg.sv
// Directed plus randomized bench for io_output_reg against an in-bench port model.
module tb_io_output_reg;

    localparam logic [31:0] OUT_RST = 32'h1234_5678;

    logic        io_clk = 0;
    logic        reset = 0;
    logic [31:0] addr = 0;
    logic [31:0] datain = 0;
    logic        write_io_enable = 0;
    logic [2:0]  out_ack = 0;
    logic [31:0] out_port0, out_port1, out_port2, io_read_data;
    logic [2:0]  out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    logic [31:0] m_port [3] = '{OUT_RST, OUT_RST, OUT_RST};
    bit          m_valid[3] = '{0, 0, 0};
    bit          m_ovr  [3] = '{0, 0, 0};

    io_output_reg #(.OUT_RESET(OUT_RST)) dut (
        .io_clk(io_clk), .reset(reset), .addr(addr), .datain(datain),
        .write_io_enable(write_io_enable), .out_ack(out_ack),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .out_valid(out_valid), .io_read_data(io_read_data)
    );

    always #5 io_clk = ~io_clk;

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int code;
        logic [31:0] r;
        code = int'(a[7:2]);
        r = 0;
        if (code >= 32 && code <= 34) r = m_port[code-32];
        else if (code == 35)
            for (int i = 0; i < 3; i++)
                r = r + (32'(m_valid[i]) << i) + (32'(m_ovr[i]) << (8 + i));
        return r;
    endfunction

    function automatic logic [2:0] exp_valid();
        return {m_valid[2], m_valid[1], m_valid[0]};
    endfunction

    // Reference model: plain per-port rules evaluated at each rising edge.
    always @(posedge io_clk) begin
        int  code;
        bit  setv[3];
        code = int'(addr[7:2]);
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_port[i] = OUT_RST; m_valid[i] = 0; m_ovr[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                setv[i] = 0;
                if (write_io_enable && code == 32 + i) begin
                    if (m_valid[i] && !out_ack[i]) setv[i] = 1;
                    m_port[i]  = datain;
                    m_valid[i] = 1;
                end else if (out_ack[i]) begin
                    m_valid[i] = 0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (write_io_enable && code == 35 && datain[8+i]) m_ovr[i] = 0;
                if (setv[i]) m_ovr[i] = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge io_clk) begin
        if (chk_en) begin
            check("model_port0", out_port0, m_port[0]);
            check("model_port1", out_port1, m_port[1]);
            check("model_port2", out_port2, m_port[2]);
            check("model_valid", 32'(out_valid), 32'(exp_valid()));
            check("model_read", io_read_data, exp_read(addr));
        end
    end

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [2:0] ack);
        reset = r; addr = a; datain = d; write_io_enable = we; out_ack = ack;
        @(posedge io_clk); #1;
        reset = 0; write_io_enable = 0; out_ack = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        @(negedge io_clk); #1;
        check(name, io_read_data, exp);
    endtask

    initial begin
        logic [5:0] code;
        step(1, 0, 0, 0, 0);
        chk_en = 1;
        rd(32'h80, OUT_RST, "rst_rd80");
        rd(32'h84, OUT_RST, "rst_rd84");
        rd(32'h88, OUT_RST, "rst_rd88");
        rd(32'h8C, 32'h0, "rst_rd8c");
        check("rst_valid", 32'(out_valid), 32'h0);

        step(0, 32'h84, 32'hDEADBEEF, 1, 3'b000);
        check("wr84_port1", out_port1, 32'hDEADBEEF);
        check("wr84_valid", 32'(out_valid), 32'h2);
        step(0, 32'h0, 32'h0, 0, 3'b010);
        check("ack1_valid", 32'(out_valid), 32'h0);
        check("ack1_port1", out_port1, 32'hDEADBEEF);

        step(0, 32'h80, 32'h1, 1, 3'b000);
        step(0, 32'h80, 32'h2, 1, 3'b000);
        check("ovr0_port0", out_port0, 32'h2);
        rd(32'h8C, 32'h0000_0101, "ovr0_status");
        step(0, 32'h8C, 32'h100, 1, 3'b000);
        rd(32'h8C, 32'h0000_0001, "w1c_status");
        step(0, 32'h0, 32'h0, 0, 3'b001);

        step(0, 32'h88, 32'hAAAA, 1, 3'b000);
        step(0, 32'h88, 32'h5555, 1, 3'b100);
        check("wrack2_valid", 32'(out_valid), 32'h4);
        check("wrack2_port2", out_port2, 32'h5555);
        rd(32'h8C, 32'h0000_0004, "wrack2_status");

        step(0, 32'h90, 32'hFFFF_FFFF, 1, 3'b000);
        check("unmap_port0", out_port0, 32'h2);
        check("unmap_valid", 32'(out_valid), 32'h4);
        rd(32'h90, 32'h0, "unmap_rd90");
        rd(32'h8C, 32'h0000_0004, "unmap_status");

        step(0, 32'h80, 32'h11, 1, 3'b000);
        step(0, 32'h80, 32'h22, 1, 3'b000);
        step(1, 32'h80, 32'h77, 1, 3'b000);
        check("rstmid_port0", out_port0, OUT_RST);
        check("rstmid_port2", out_port2, OUT_RST);
        check("rstmid_valid", 32'(out_valid), 32'h0);
        rd(32'h8C, 32'h0, "rstmid_status");

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0: code = 6'd32;
                1: code = 6'd33;
                2: code = 6'd34;
                3: code = 6'd35;
                4: code = 6'd36;
                default: code = 6'($urandom_range(0, 63));
            endcase
            step(($urandom_range(0, 49) == 0),
                 {$urandom_range(0, 255) == 0 ? 24'($urandom) : 24'h0, code, 2'($urandom)},
                 $urandom, ($urandom_range(0, 2) != 0), 3'($urandom));
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
